// File: rtl/mem_refill_arbiter_pkg.sv
// Shared definitions for the cache-miss memory arbiter: arbiter state
// encodings, default line geometry and the line-offset width helper.
package mem_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFILL  = 2'd1,
    ARB_DFILL  = 2'd2,
    ARB_DSTORE = 2'd3
  } arb_state_e;

  localparam int ARB_LINE_WORDS = 4;

  // Byte-offset width of a cache line: word index bits plus the 2 byte bits.
  function automatic int line_offset(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/mem_refill_arbiter.sv
// Arbitrates I-cache and D-cache miss traffic onto one single-port memory:
// line refills for both caches and single-word write-through stores for the D-cache.
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = ARB_LINE_WORDS
) (
  input  logic                          Clk,
  input  logic                          Rst,
  // I-cache side
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic                          i_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] i_widx,
  output logic [DATA_W-1:0]             i_rdata,
  output logic                          i_done,
  // D-cache side
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] d_widx,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_done,
  // Memory port
  output logic                          mem_valid,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int WIDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = line_offset(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(LINE_WORDS - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [WIDX_W-1:0] r_cnt,   w_cnt_nxt;
  logic [ADDR_W-1:0] r_base,  w_base_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;

  logic w_busy, w_ifill, w_dfill, w_store, w_last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_base_nxt  = r_base;
    w_wdata_nxt = r_wdata;
    unique case (r_state)
      ARB_IDLE: begin
        // D-side wins: its miss belongs to the older instruction in MA.
        if (d_req) begin
          w_state_nxt = d_we ? ARB_DSTORE : ARB_DFILL;
          w_base_nxt  = d_addr & (d_we ? WORD_MASK : LINE_MASK);
          w_wdata_nxt = d_wdata;
        end else if (i_req) begin
          w_state_nxt = ARB_IFILL;
          w_base_nxt  = i_addr & LINE_MASK;
        end
      end
      ARB_IFILL, ARB_DFILL: begin
        if (mem_ready) begin
          w_cnt_nxt = r_cnt + WIDX_W'(1);
          if (r_cnt == LAST_IDX) w_state_nxt = ARB_IDLE;
        end
      end
      ARB_DSTORE: begin
        if (mem_ready) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_base  <= w_base_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Outputs are held low while Rst is high so an aborted line never signals done.
  assign w_busy  = !Rst && (r_state != ARB_IDLE);
  assign w_ifill = !Rst && (r_state == ARB_IFILL);
  assign w_dfill = !Rst && (r_state == ARB_DFILL);
  assign w_store = !Rst && (r_state == ARB_DSTORE);
  assign w_last  = (r_cnt == LAST_IDX);

  assign mem_valid = w_busy;
  assign mem_we    = w_store;
  assign mem_addr  = w_busy  ? (r_base | ADDR_W'({r_cnt, 2'b00})) : '0;
  assign mem_wdata = w_store ? r_wdata : '0;

  assign i_rvalid = w_ifill && mem_ready;
  assign i_widx   = i_rvalid ? r_cnt : '0;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign i_done   = i_rvalid && w_last;

  assign d_rvalid = w_dfill && mem_ready;
  assign d_widx   = d_rvalid ? r_cnt : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign d_done   = (d_rvalid && w_last) || (w_store && mem_ready);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed self-checking bench for mem_refill_arbiter: refills, D priority,
// stalled store, stalled refill and mid-line reset.
module tb_mem_refill_arbiter;

  logic        Clk;
  logic        Rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [1:0]  i_widx;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [1:0]  d_widx;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_refill_arbiter dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_widx   (i_widx),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rvalid (d_rvalid),
    .d_widx   (d_widx),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always_comb mem_rdata = mem_model(mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One line refill; stalls holds a 4-bit wait-state count per word, word 0 in the low nibble.
  task automatic expect_fill(input bit is_d, input logic [31:0] base, input logic [15:0] stalls);
    for (int w = 0; w < 4; w++) begin
      int ns;
      logic [31:0] a;
      ns = int'(stalls[w*4 +: 4]);
      a  = base + 32'(w * 4);
      for (int s = 0; s < ns; s++) begin
        @(negedge Clk); mem_ready = 1'b0; #1;
        check("stall_valid",  {63'd0, mem_valid}, 64'd1);
        check("stall_addr",   {32'd0, mem_addr}, {32'd0, a});
        check("stall_rvalid", {63'd0, i_rvalid | d_rvalid}, 64'd0);
        check("stall_done",   {63'd0, i_done | d_done}, 64'd0);
      end
      @(negedge Clk); mem_ready = 1'b1; #1;
      check("fill_valid",  {63'd0, mem_valid}, 64'd1);
      check("fill_we",     {63'd0, mem_we}, 64'd0);
      check("fill_addr",   {32'd0, mem_addr}, {32'd0, a});
      check("fill_rvalid", {63'd0, is_d ? d_rvalid : i_rvalid}, 64'd1);
      check("fill_other_rvalid", {63'd0, is_d ? i_rvalid : d_rvalid}, 64'd0);
      check("fill_widx",   {62'd0, is_d ? d_widx : i_widx}, 64'(w));
      check("fill_rdata",  {32'd0, is_d ? d_rdata : i_rdata}, {32'd0, mem_model(a)});
      check("fill_done",   {63'd0, is_d ? d_done : i_done}, {63'd0, w == 3});
      check("fill_other_done", {63'd0, is_d ? i_done : d_done}, 64'd0);
    end
  endtask

  task automatic expect_idle(input string tag);
    #1;
    check({tag, "_valid"}, {63'd0, mem_valid}, 64'd0);
    check({tag, "_done"},  {62'd0, i_done, d_done}, 64'd0);
    check({tag, "_rvalid"}, {62'd0, i_rvalid, d_rvalid}, 64'd0);
  endtask

  initial begin
    Rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0;

    // Reset then idle for 10 cycles.
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    check("rst_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_rdata", {32'd0, i_rdata | d_rdata}, 64'd0);
    Rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk); mem_ready = (c % 2 == 1);
      expect_idle("idle");
    end

    // Simple I refill, memory always ready.
    @(negedge Clk); i_req = 1'b1; i_addr = 32'h1234; mem_ready = 1'b1;
    expect_fill(1'b0, 32'h1230, 16'h0000);
    @(negedge Clk); i_req = 1'b0;
    expect_idle("i_after");

    // Simultaneous requests: D line first, idle gap, then I line.
    @(negedge Clk);
    i_req = 1'b1; i_addr = 32'h1234;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    expect_fill(1'b1, 32'h80, 16'h0000);
    @(negedge Clk); d_req = 1'b0;
    expect_idle("gap");
    expect_fill(1'b0, 32'h1230, 16'h0000);
    @(negedge Clk); i_req = 1'b0;
    expect_idle("both_after");

    // Store with 3 wait states; requester inputs change after grant and must be ignored.
    @(negedge Clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge Clk);
      d_addr = 32'h9999_0000; d_wdata = 32'h0BAD_F00D;
      mem_ready = (s == 3);
      #1;
      check("st_valid", {63'd0, mem_valid}, 64'd1);
      check("st_we",    {63'd0, mem_we}, 64'd1);
      check("st_addr",  {32'd0, mem_addr}, 64'h40);
      check("st_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
      check("st_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
      check("st_done",  {63'd0, d_done}, {63'd0, s == 3});
    end
    @(negedge Clk); d_req = 1'b0; d_we = 1'b0;
    expect_idle("st_after");

    // I refill with irregular wait states.
    @(negedge Clk); i_req = 1'b1; i_addr = 32'h0002_004C;
    expect_fill(1'b0, 32'h0002_0040, 16'h2031);
    @(negedge Clk); i_req = 1'b0;
    expect_idle("stall_after");

    // Reset after 2 of 4 words.
    @(negedge Clk); i_req = 1'b1; i_addr = 32'h500; mem_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      @(negedge Clk); #1;
      check("pre_rst_widx", {62'd0, i_widx}, 64'(w));
      check("pre_rst_addr", {32'd0, mem_addr}, 64'(32'h500 + 32'(w * 4)));
    end
    @(negedge Clk); Rst = 1'b1; #1;
    check("in_rst_done", {63'd0, i_done}, 64'd0);
    @(negedge Clk); Rst = 1'b0; i_req = 1'b0;
    expect_idle("post_rst");
    @(negedge Clk); i_req = 1'b1; i_addr = 32'h600;
    expect_fill(1'b0, 32'h600, 16'h0000);
    @(negedge Clk); i_req = 1'b0;
    expect_idle("restart_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
